// File: rtl/ring_step_ctrl.sv
// Button conditioning (2-flop sync + debounce + press pulse) and a run/stop FSM
// driving a speed-selectable prescaler that emits one-cycle advance strobes.
module ring_step_ctrl #(
    parameter int DB_CNT   = 1000000,
    parameter int BASE_DIV = 2097152,
    parameter int DIV_W    = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_speed,
    output logic       en,
    output logic       running,
    output logic [1:0] speed
);

    localparam int CNT_W = $clog2(DB_CNT);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CNT - 1);

    typedef enum logic {STOPPED, RUNNING} state_t;

    // Bit 0 = run, bit 1 = step, bit 2 = speed
    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       stable;
    logic [2:0]       press;
    logic [CNT_W-1:0] db_cnt [3];

    assign raw = {btn_speed, btn_step, btn_run};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            press  <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    press[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic run_p;
    logic step_p;
    logic speed_p;

    assign run_p   = press[0];
    assign step_p  = press[1];
    assign speed_p = press[2];

    state_t           state;
    state_t           state_nx;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] presc_nx;
    logic [DIV_W-1:0] period_m1;
    logic             en_nx;
    logic [1:0]       speed_nx;

    always_comb begin
        state_nx  = state;
        presc_nx  = presc;
        en_nx     = 1'b0;
        speed_nx  = speed;
        period_m1 = DIV_W'((BASE_DIV >> speed) - 1);

        if (state == STOPPED) begin
            presc_nx = '0;
            if (run_p) begin
                state_nx = RUNNING;
            end else if (step_p) begin
                en_nx = 1'b1;
            end
        end else begin
            if (run_p) begin
                state_nx = STOPPED;
                presc_nx = '0;
            end else if (presc == period_m1) begin
                presc_nx = '0;
                en_nx    = 1'b1;
            end else begin
                presc_nx = presc + 1'b1;
            end
        end

        // A speed change restarts the period; a tick due on that same edge is
        // dropped so the first strobe at the new speed is a full period away.
        if (speed_p) begin
            speed_nx = speed + 1'b1;
            presc_nx = '0;
            if (state == RUNNING) begin
                en_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STOPPED;
            presc <= '0;
            en    <= 1'b0;
            speed <= '0;
        end else begin
            state <= state_nx;
            presc <= presc_nx;
            en    <= en_nx;
            speed <= speed_nx;
        end
    end

    assign running = (state == RUNNING);

endmodule

// File: tb/tb_ring_step_ctrl.sv
// Self-checking bench for ring_step_ctrl: directed scenarios plus randomized
// button activity, all compared against a time-based behavioural model.
module tb_ring_step_ctrl;

    localparam int DB = 4;
    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_run;
    logic       btn_step;
    logic       btn_speed;
    logic       en;
    logic       running;
    logic [1:0] speed;

    int tests = 0;
    int fails = 0;

    ring_step_ctrl #(.DB_CNT(DB), .BASE_DIV(BD), .DIV_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_step  (btn_step),
        .btn_speed (btn_speed),
        .en        (en),
        .running   (running),
        .speed     (speed)
    );

    always #5 clk = ~clk;

    // Model: stable level takes the synchronised value once that value has
    // differed from it on each of the last DB edges; ticks scheduled by time.
    bit     rh [3][$];
    bit     win[3][$];
    bit     st [3];
    bit     mp [3];
    bit     m_en;
    bit     m_running;
    int     m_speed;
    longint cyc;
    longint next_tick;

    function automatic void model_reset();
        for (int b = 0; b < 3; b++) begin
            rh[b].delete();
            win[b].delete();
            st[b] = 1'b0;
            mp[b] = 1'b0;
        end
        m_en      = 1'b0;
        m_running = 1'b0;
        m_speed   = 0;
        next_tick = 0;
    endfunction

    function automatic void model_edge();
        bit raw[3];
        bit run_p, step_p, spd_p, s2, all_diff;
        int p;
        if (rst) begin
            model_reset();
            return;
        end
        cyc++;
        raw[0] = btn_run;
        raw[1] = btn_step;
        raw[2] = btn_speed;
        run_p  = mp[0];
        step_p = mp[1];
        spd_p  = mp[2];

        m_en = 1'b0;
        if (spd_p) m_speed = (m_speed + 1) % 4;
        p = BD >> m_speed;
        if (m_running) begin
            if (run_p) begin
                m_running = 1'b0;
            end else if (spd_p) begin
                next_tick = cyc + p;
            end else if (cyc == next_tick) begin
                m_en      = 1'b1;
                next_tick = cyc + p;
            end
        end else if (run_p) begin
            m_running = 1'b1;
            next_tick = cyc + p;
        end else if (step_p) begin
            m_en = 1'b1;
        end

        for (int b = 0; b < 3; b++) begin
            s2 = (rh[b].size() >= 2) ? rh[b][rh[b].size() - 2] : 1'b0;
            rh[b].push_back(raw[b]);
            if (rh[b].size() > 2) void'(rh[b].pop_front());
            win[b].push_back(s2);
            if (win[b].size() > DB) void'(win[b].pop_front());
            all_diff = (win[b].size() == DB);
            foreach (win[b][j]) if (win[b][j] == st[b]) all_diff = 1'b0;
            mp[b] = 1'b0;
            if (all_diff) begin
                st[b] = s2;
                mp[b] = s2;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; btn_speed = 1'b0;
        model_reset();
        cyc = 0;
        repeat (3) tick();
        tests++;
        if ({en, running, speed} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_state: got en=%b running=%b speed=%0d, want 0/0/0", en, running, speed);
        end
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            tests++;
            if ({en, running, speed} !== 4'b0000) begin
                fails++;
                $display("FAIL idle k=%0d: got en=%b running=%b speed=%0d, want 0/0/0", k, en, running, speed);
            end
        end
    endtask

    task automatic test_run();
        int n_en = 0;
        int first = -1;
        btn_run = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (k == 10) btn_run = 1'b0;
            tests++;
            if ({en, running, speed} !== {m_en, m_running, 2'(m_speed)}) begin
                fails++;
                $display("FAIL run_model k=%0d: got en=%b running=%b speed=%0d, want %b/%b/%0d",
                         k, en, running, speed, m_en, m_running, m_speed);
            end
            if (k == 6 || k == 7) begin
                tests++;
                if (running !== (k == 7)) begin
                    fails++;
                    $display("FAIL run_entry k=%0d: got running=%b, want %b", k, running, k == 7);
                end
            end
            if (en && k >= 8 && k <= 71) begin
                n_en++;
                if (first < 0) first = k;
            end
        end
        tests++;
        if (n_en != 4 || first != 23) begin
            fails++;
            $display("FAIL run_ticks: got %0d pulses first at %0d, want 4 first at 23", n_en, first);
        end
    endtask

    task automatic test_speed();
        for (int p = 0; p < 4; p++) begin
            int old = int'(speed);
            int sc = -1, fe = -1, se = -1;
            int per = BD >> ((p + 1) % 4);
            btn_speed = 1'b1;
            for (int k = 1; k <= 44; k++) begin
                tick();
                if (k == 6) btn_speed = 1'b0;
                tests++;
                if ({en, running, speed} !== {m_en, m_running, 2'(m_speed)}) begin
                    fails++;
                    $display("FAIL speed_model p=%0d k=%0d: got en=%b running=%b speed=%0d, want %b/%b/%0d",
                             p, k, en, running, speed, m_en, m_running, m_speed);
                end
                if (sc < 0 && int'(speed) != old) sc = k;
                else if (sc > 0 && en) begin
                    if (fe < 0) fe = k;
                    else if (se < 0) se = k;
                end
            end
            tests++;
            if (int'(speed) != (p + 1) % 4 || sc != 7 || fe - sc != per || se - fe != per) begin
                fails++;
                $display("FAIL speed_period p=%0d: got speed=%0d change@%0d gaps %0d,%0d, want speed=%0d change@7 gaps %0d,%0d",
                         p, speed, sc, fe - sc, se - fe, (p + 1) % 4, per, per);
            end
        end
    endtask

    task automatic test_step();
        int n_en = 0;
        bit ran = 1'b0;
        btn_run = 1'b1;
        repeat (8) tick();
        btn_run = 1'b0;
        repeat (12) tick();
        tests++;
        if (running !== 1'b0) begin
            fails++;
            $display("FAIL step_stop: got running=%b, want 0", running);
        end
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 20; k++) begin
                btn_step = (k < 10);
                tick();
                tests++;
                if ({en, running, speed} !== {m_en, m_running, 2'(m_speed)}) begin
                    fails++;
                    $display("FAIL step_model s=%0d k=%0d: got en=%b running=%b speed=%0d, want %b/%b/%0d",
                             s, k, en, running, speed, m_en, m_running, m_speed);
                end
                n_en += int'(en);
                ran |= running;
            end
        end
        btn_step = 1'b0;
        tests++;
        if (n_en != 3 || ran) begin
            fails++;
            $display("FAIL step_pulses: got %0d pulses running_seen=%b, want 3 and 0", n_en, ran);
        end
    endtask

    task automatic test_bounce();
        int n_en = 0;
        bit pat[6] = '{1, 0, 1, 0, 1, 0};
        for (int k = 0; k < 16; k++) begin
            btn_step = (k < 6) ? pat[k] : 1'b0;
            tick();
            n_en += int'(en);
        end
        tests++;
        if (n_en != 0) begin
            fails++;
            $display("FAIL bounce_toggle: got %0d pulses, want 0", n_en);
        end
        for (int k = 0; k < 15; k++) begin
            btn_step = (k < 3);
            tick();
            n_en += int'(en);
        end
        btn_step = 1'b0;
        tests++;
        if (n_en != 0) begin
            fails++;
            $display("FAIL bounce_short: got %0d pulses, want 0", n_en);
        end
    endtask

    task automatic test_async_reset();
        btn_speed = 1'b1;
        repeat (6) tick();
        btn_speed = 1'b0;
        repeat (10) tick();
        btn_run = 1'b1;
        repeat (30) tick();
        tests++;
        if (running !== 1'b1 || speed !== 2'd1) begin
            fails++;
            $display("FAIL areset_setup: got running=%b speed=%0d, want 1/1", running, speed);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if ({en, running, speed} !== 4'b0000) begin
            fails++;
            $display("FAIL areset_immediate: got en=%b running=%b speed=%0d, want 0/0/0", en, running, speed);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (en !== 1'b0) begin
                fails++;
                $display("FAIL areset_en: got en=%b during reset, want 0", en);
            end
        end
        #2;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            tests++;
            if ({en, running, speed} !== {m_en, m_running, 2'(m_speed)}) begin
                fails++;
                $display("FAIL areset_model k=%0d: got en=%b running=%b speed=%0d, want %b/%b/%0d",
                         k, en, running, speed, m_en, m_running, m_speed);
            end
            if (k == 6 || k == 7) begin
                tests++;
                if (running !== (k == 7) || speed !== 2'd0) begin
                    fails++;
                    $display("FAIL areset_repress k=%0d: got running=%b speed=%0d, want %b/0",
                             k, running, speed, k == 7);
                end
            end
        end
        btn_run = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_random();
        int  remain = 0;
        bit  prev_en = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (remain == 0) begin
                btn_run   = ($urandom_range(0, 7) == 0);
                btn_step  = ($urandom_range(0, 3) == 0);
                btn_speed = ($urandom_range(0, 5) == 0);
                remain    = $urandom_range(1, 12);
            end
            remain--;
            tick();
            tests++;
            if ({en, running, speed} !== {m_en, m_running, 2'(m_speed)} || (en && prev_en)) begin
                fails++;
                $display("FAIL random i=%0d: got en=%b running=%b speed=%0d prev_en=%b, want %b/%b/%0d",
                         i, en, running, speed, prev_en, m_en, m_running, m_speed);
            end
            prev_en = en;
        end
        btn_run = 1'b0; btn_step = 1'b0; btn_speed = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run();
        test_speed();
        test_step();
        test_bounce();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
